fan_tach_reader: RTL and testbench
==================================

# fan_tach_reader

Measures fan speed from the open-drain tachometer line of the PWM-driven fan, closing the loop opposite the PWM output path. The tach input is synchronised, glitch-filtered and edge-detected. Rising edges are counted over a fixed gate window, and each completed window publishes a count with a one-cycle valid strobe plus a stall flag. The result feeds the controller as the measured-speed input alongside the ADC temperature path.

## Interface
- `GATE_TICKS`, 250000: clk_i cycles per measurement window; ≥ 2.
- `GATE_BITWIDTH`, 18: window counter width; 2**GATE_BITWIDTH > GATE_TICKS.
- `COUNT_BITWIDTH`, 8: pulse count width; saturating.
- `FILTER_LEN`, 4: consecutive equal synchronised samples needed to accept a level change; ≥ 1.
- `STALL_WINDOWS`, 2: consecutive zero-count windows that assert stall; ≥ 1.
- `PERIOD_BITWIDTH`, 20: edge-to-edge period width; saturating.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `enable_i`, in, 1: measurement enable.
- `tach_i`, in, 1: asynchronous tach line, idle high (pull-up).
- `pulse_count_o`, out, COUNT_BITWIDTH: filtered rising edges in last completed window.
- `count_valid_o`, out, 1: one-cycle strobe on `pulse_count_o` update.
- `stall_o`, out, 1: fan stalled.
- `period_o`, out, PERIOD_BITWIDTH: clk_i cycles between the last two filtered rising edges.

## Operation
- **Synchroniser**
  - Two flops on `tach_i`, both reset to 1.
- **Filter**
  - Filtered level resets to 1 and the run counter resets to 0.
  - The run counter increments while the synchronised sample differs from the filtered level. It clears when they match.
  - When the counter reaches FILTER_LEN, the filtered level flips and the counter clears.
  - Pulses shorter than FILTER_LEN cycles are rejected.
  - The filter runs regardless of `enable_i`.
- **Edge detect**
  - `rise` is high for one cycle when the filtered level goes 0→1.
- **Window**
  - Counter runs 0..GATE_TICKS-1 and wraps.
  - On the terminal cycle (counter = GATE_TICKS-1), `pulse_count_o` takes accumulator + `rise`, saturating at all-ones.
  - On the terminal cycle, the accumulator clears and `count_valid_o` pulses.
  - A `rise` on the terminal cycle counts in the closing window, not the next.
  - The accumulator saturates at all-ones.
- **Stall**
  - Zero-run counter: +1 on each window closing with result 0, saturating at STALL_WINDOWS. Cleared on a nonzero result.
  - `stall_o` is updated on the same edge as `pulse_count_o`: 1 iff the new zero-run value ≥ STALL_WINDOWS.
- **`enable_i` low**
  - Window counter, accumulator and zero-run counter are held at 0.
  - `stall_o` is cleared.
  - No strobes are issued.
  - `pulse_count_o` and `period_o` hold their values.
- **`enable_i` re-asserted**
  - The first window is a full GATE_TICKS cycles.
- **State (window/reporting path)**
  - IDLE (enable low) → COUNT (enable high).
  - COUNT terminal cycle → COUNT, with the report registered.
  - Any cycle with enable low → IDLE.

## Timing
- Reset values:
  - All outputs 0.
  - Synchroniser and filtered level 1, so there is no spurious edge when reset is released.
- A `tach_i` transition meeting setup is visible as a filtered level change 2+FILTER_LEN clk_i edges later. `rise` asserts in that same cycle.
- `count_valid_o` is high exactly one cycle, the cycle after the terminal-cycle edge. Strobes are GATE_TICKS cycles apart.
- First strobe after reset release, with `enable_i` high: after the GATE_TICKS-th rising edge of clk_i.
- `rst_i` mid-window: the partial window is discarded immediately and asynchronously. No strobe is issued for it.

## Configuration
- `FAN_TACH_PERIOD_EN` **defined**:
  - A period counter clears on each `rise` and otherwise increments, saturating at all-ones.
  - On `rise`, `period_o` takes counter+1 (saturating), provided an earlier `rise` has occurred since reset or enable.
  - The first `rise` after reset or enable only arms the counter.
  - When `stall_o` asserts, `period_o` is set to all-ones.
- `FAN_TACH_PERIOD_EN` **undefined**:
  - `period_o` is tied to 0 and no period logic is built.
  - The port list is unchanged.

## Test plan
Bench parameters: GATE_TICKS=100, FILTER_LEN=3, STALL_WINDOWS=2, macro defined.
- **Reset:** assert `rst_i` at cycle 50 of a window with tach toggling, then release with enable=1.
  - All outputs 0 during reset.
  - First `count_valid_o` after the 100th clk edge post-release.
- **Steady tach:** 10-cycle square wave (5 high / 5 low).
  - `pulse_count_o`=10 on every strobe.
  - `period_o`=10.
  - `stall_o`=0.
- **Glitch rejection:** tach high with 2-cycle low pulses every 7 cycles.
  - `pulse_count_o`=0.
  - `stall_o`=1 on the 2nd strobe.
  - `period_o` all-ones.
- **Stall recovery:** after stall, apply the 10-cycle wave.
  - `stall_o`=0 at the first strobe with a nonzero count.
- **Saturation:** COUNT_BITWIDTH=3, 8-cycle wave (4 high / 4 low).
  - `pulse_count_o`=7 on every strobe.
- **Terminal-cycle edge and enable:**
  - Place a filtered rise on counter=99 → it counts in the closing window; the next window does not include it.
  - Drop `enable_i` mid-window → no strobe, `pulse_count_o` holds, `stall_o`=0.
  - Re-enable → next strobe exactly 100 cycles later.

Source files
------------

// File: rtl/fan_tach_reader_if.sv
// Fan tach reader bus: enable/tach in, measured speed out.
interface fan_tach_reader_if #(
  parameter int unsigned COUNT_BITWIDTH  = 8,
  parameter int unsigned PERIOD_BITWIDTH = 20
);
  logic                       enable_i;
  logic                       tach_i;
  logic [COUNT_BITWIDTH-1:0]  pulse_count_o;
  logic                       count_valid_o;
  logic                       stall_o;
  logic [PERIOD_BITWIDTH-1:0] period_o;

  // Controller side: drives enable/tach, consumes the measurement.
  modport master (
    output enable_i,
    output tach_i,
    input  pulse_count_o,
    input  count_valid_o,
    input  stall_o,
    input  period_o
  );

  // Reader side.
  modport slave (
    input  enable_i,
    input  tach_i,
    output pulse_count_o,
    output count_valid_o,
    output stall_o,
    output period_o
  );
endinterface

// File: rtl/fan_tach_reader.sv
// Fan tachometer reader: synchronise, glitch-filter and edge-detect the tach line, count rising
// edges over a fixed gate window, and report count, stall and (optionally) edge-to-edge period.
// Optional feature macro: FAN_TACH_PERIOD_EN enables the period measurement; when undefined
// period_o is tied to zero.
module fan_tach_reader #(
  parameter int unsigned GATE_TICKS      = 250000,
  parameter int unsigned GATE_BITWIDTH   = 18,
  parameter int unsigned COUNT_BITWIDTH  = 8,
  parameter int unsigned FILTER_LEN      = 4,
  parameter int unsigned STALL_WINDOWS   = 2,
  parameter int unsigned PERIOD_BITWIDTH = 20
) (
  input logic              clk_i,
  input logic              rst_i,
  fan_tach_reader_if.slave bus
);

  localparam int unsigned RunW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned ZrW  = $clog2(STALL_WINDOWS + 1);

  localparam logic [RunW-1:0]          RunLast  = RunW'(FILTER_LEN - 1);
  localparam logic [GATE_BITWIDTH-1:0] GateLast = GATE_BITWIDTH'(GATE_TICKS - 1);
  localparam logic [ZrW-1:0]           ZrMax    = ZrW'(STALL_WINDOWS);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  logic                      r_sync1, r_sync2;
  logic                      r_filt, r_filt_dly;
  logic [RunW-1:0]           r_run;
  state_e                    r_state;
  logic [GATE_BITWIDTH-1:0]  r_gate;
  logic [COUNT_BITWIDTH-1:0] r_acc;
  logic [ZrW-1:0]            r_zr;
  logic [COUNT_BITWIDTH-1:0] r_pulse_count;
  logic                      r_valid;
  logic                      r_stall;

  logic                      w_rise;
  logic                      w_gate_last;
  logic [COUNT_BITWIDTH-1:0] w_acc_inc;
  logic [ZrW-1:0]            w_zr_next;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.tach_i;
      r_sync2 <= r_sync1;
    end
  end

  // Run-length filter: level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_filt     <= 1'b1;
      r_filt_dly <= 1'b1;
      r_run      <= '0;
    end else begin
      r_filt_dly <= r_filt;
      if (r_sync2 != r_filt) begin
        if (r_run == RunLast) begin
          r_filt <= ~r_filt;
          r_run  <= '0;
        end else begin
          r_run <= r_run + RunW'(1);
        end
      end else begin
        r_run <= '0;
      end
    end
  end

  // Edge detect, saturating accumulate and next zero-run value for the closing window.
  always_comb begin
    w_rise      = r_filt & ~r_filt_dly;
    w_gate_last = (r_gate == GateLast);
    w_acc_inc   = r_acc;
    if (w_rise && (r_acc != {COUNT_BITWIDTH{1'b1}})) begin
      w_acc_inc = r_acc + COUNT_BITWIDTH'(1);
    end
    w_zr_next = '0;
    if (w_acc_inc == '0) begin
      w_zr_next = (r_zr == ZrMax) ? r_zr : r_zr + ZrW'(1);
    end
  end

  // Window/reporting FSM: IDLE while disabled, COUNT while enabled; reports on the terminal cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= StIdle;
      r_gate        <= '0;
      r_acc         <= '0;
      r_zr          <= '0;
      r_pulse_count <= '0;
      r_valid       <= 1'b0;
      r_stall       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!bus.enable_i) begin
        r_state <= StIdle;
        r_gate  <= '0;
        r_acc   <= '0;
        r_zr    <= '0;
        r_stall <= 1'b0;
      end else begin
        // The first enabled cycle already counts as window cycle 0.
        if (r_state == StIdle) begin
          r_state <= StCount;
        end
        if (w_gate_last) begin
          r_gate        <= '0;
          r_acc         <= '0;
          r_pulse_count <= w_acc_inc;
          r_valid       <= 1'b1;
          r_zr          <= w_zr_next;
          r_stall       <= (w_zr_next >= ZrMax);
        end else begin
          r_gate <= r_gate + GATE_BITWIDTH'(1);
          r_acc  <= w_acc_inc;
        end
      end
    end
  end

  assign bus.pulse_count_o = r_pulse_count;
  assign bus.count_valid_o = r_valid;
  assign bus.stall_o       = r_stall;

`ifdef FAN_TACH_PERIOD_EN
  logic [PERIOD_BITWIDTH-1:0] r_per_cnt;
  logic [PERIOD_BITWIDTH-1:0] r_period;
  logic                       r_armed;
  logic [PERIOD_BITWIDTH-1:0] w_per_inc;

  // Saturating increment shared by the free-running counter and the published period.
  always_comb begin
    w_per_inc = r_per_cnt;
    if (r_per_cnt != {PERIOD_BITWIDTH{1'b1}}) begin
      w_per_inc = r_per_cnt + PERIOD_BITWIDTH'(1);
    end
  end

  // Edge-to-edge period; the first rise only arms, and a stalled window forces all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_per_cnt <= '0;
      r_period  <= '0;
      r_armed   <= 1'b0;
    end else begin
      if (!bus.enable_i) begin
        r_per_cnt <= '0;
        r_armed   <= 1'b0;
      end else if (w_rise) begin
        r_per_cnt <= '0;
        r_armed   <= 1'b1;
        if (r_armed) begin
          r_period <= w_per_inc;
        end
      end else begin
        r_per_cnt <= w_per_inc;
      end
      if (bus.enable_i && w_gate_last && (w_zr_next >= ZrMax)) begin
        r_period <= {PERIOD_BITWIDTH{1'b1}};
      end
    end
  end

  assign bus.period_o = r_period;
`else
  assign bus.period_o = {PERIOD_BITWIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_fan_tach_reader.sv
// Directed bench for fan_tach_reader: GATE_TICKS=100, FILTER_LEN=3, STALL_WINDOWS=2, plus a
// second instance with a 3-bit count for saturation.
module tb_fan_tach_reader;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ph = 0;
  int   mode = 1;

`ifdef FAN_TACH_PERIOD_EN
  localparam logic [19:0] PerTen  = 20'd10;
  localparam logic [19:0] PerOnes = 20'hFFFFF;
`else
  localparam logic [19:0] PerTen  = 20'd0;
  localparam logic [19:0] PerOnes = 20'd0;
`endif

  always #5 clk = ~clk;

  fan_tach_reader_if #(.COUNT_BITWIDTH(8), .PERIOD_BITWIDTH(20)) bus ();
  fan_tach_reader_if #(.COUNT_BITWIDTH(3), .PERIOD_BITWIDTH(20)) sat_bus ();

  fan_tach_reader #(
    .GATE_TICKS(100), .GATE_BITWIDTH(7), .COUNT_BITWIDTH(8),
    .FILTER_LEN(3), .STALL_WINDOWS(2), .PERIOD_BITWIDTH(20)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  fan_tach_reader #(
    .GATE_TICKS(100), .GATE_BITWIDTH(7), .COUNT_BITWIDTH(3),
    .FILTER_LEN(3), .STALL_WINDOWS(2), .PERIOD_BITWIDTH(20)
  ) u_dut_sat (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (sat_bus)
  );

  // 0: high, 1: 5 high / 5 low, 2: high with 2-cycle low glitch every 7, 3: low.
  function automatic logic wave(input int m, input int p);
    case (m)
      1:       return ((p % 10) < 5);
      2:       return ((p % 7) >= 2);
      3:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ph++;
    bus.tach_i     = wave(mode, ph);
    sat_bus.tach_i = ((ph % 8) < 4);
  endtask

  task automatic set_mode(input int m);
    mode       = m;
    bus.tach_i = wave(m, ph);
  endtask

  // Returns the number of ticks until count_valid_o is seen, or -1 on timeout.
  task automatic wait_strobe(input bit sat, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (sat ? sat_bus.count_valid_o : bus.count_valid_o) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst             = 1'b1;
    bus.enable_i    = 1'b1;
    sat_bus.enable_i = 1'b1;
    set_mode(1);
    repeat (3) tick();
    n_cmp++;
    if (bus.pulse_count_o !== 8'd0) begin
      n_bad++; $display("FAIL reset_count: got %0d want 0", bus.pulse_count_o);
    end
    n_cmp++;
    if ({bus.count_valid_o, bus.stall_o} !== 2'b00) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00", {bus.count_valid_o, bus.stall_o});
    end
    n_cmp++;
    if (bus.period_o !== 20'd0) begin
      n_bad++; $display("FAIL reset_period: got %0d want 0", bus.period_o);
    end
    rst = 1'b0;
    wait_strobe(1'b0, 150, n);
    n_cmp++;
    if (n !== 100) begin
      n_bad++; $display("FAIL first_strobe: got %0d ticks want 100", n);
    end
    // Reset mid-window must clear the published count at once.
    repeat (50) tick();
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.pulse_count_o !== 8'd0) begin
      n_bad++; $display("FAIL async_reset_count: got %0d want 0", bus.pulse_count_o);
    end
    n_cmp++;
    if (bus.period_o !== 20'd0) begin
      n_bad++; $display("FAIL async_reset_period: got %0d want 0", bus.period_o);
    end
    repeat (2) tick();
    rst = 1'b0;
    wait_strobe(1'b0, 150, n);
    n_cmp++;
    if (n !== 100) begin
      n_bad++; $display("FAIL strobe_after_midreset: got %0d ticks want 100", n);
    end
  endtask

  task automatic test_steady();
    int n;
    for (int i = 0; i < 3; i++) begin
      wait_strobe(1'b0, 150, n);
      n_cmp++;
      if (n !== 100) begin
        n_bad++; $display("FAIL steady_spacing[%0d]: got %0d want 100", i, n);
      end
      n_cmp++;
      if (bus.pulse_count_o !== 8'd10) begin
        n_bad++; $display("FAIL steady_count[%0d]: got %0d want 10", i, bus.pulse_count_o);
      end
      n_cmp++;
      if (bus.period_o !== PerTen) begin
        n_bad++; $display("FAIL steady_period[%0d]: got %0d want %0d", i, bus.period_o, PerTen);
      end
      n_cmp++;
      if (bus.stall_o !== 1'b0) begin
        n_bad++; $display("FAIL steady_stall[%0d]: got %b want 0", i, bus.stall_o);
      end
    end
    tick();
    n_cmp++;
    if (bus.count_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL strobe_width: got %b want 0 one cycle after", bus.count_valid_o);
    end
  endtask

  task automatic test_glitch();
    int n;
    repeat (49) tick();
    set_mode(2);
    wait_strobe(1'b0, 150, n);
    wait_strobe(1'b0, 150, n);
    n_cmp++;
    if ({bus.pulse_count_o, bus.stall_o} !== {8'd0, 1'b0}) begin
      n_bad++; $display("FAIL glitch_first: got count %0d stall %b want 0 0",
                        bus.pulse_count_o, bus.stall_o);
    end
    wait_strobe(1'b0, 150, n);
    n_cmp++;
    if ({bus.pulse_count_o, bus.stall_o} !== {8'd0, 1'b1}) begin
      n_bad++; $display("FAIL glitch_stall: got count %0d stall %b want 0 1",
                        bus.pulse_count_o, bus.stall_o);
    end
    n_cmp++;
    if (bus.period_o !== PerOnes) begin
      n_bad++; $display("FAIL stall_period: got %0h want %0h", bus.period_o, PerOnes);
    end
    wait_strobe(1'b0, 150, n);
    n_cmp++;
    if (bus.stall_o !== 1'b1) begin
      n_bad++; $display("FAIL stall_held: got %b want 1", bus.stall_o);
    end
  endtask

  task automatic test_recovery();
    int n;
    set_mode(1);
    wait_strobe(1'b0, 150, n);
    n_cmp++;
    if (bus.pulse_count_o === 8'd0) begin
      n_bad++; $display("FAIL recovery_count: got 0 want nonzero");
    end
    n_cmp++;
    if (bus.stall_o !== 1'b0) begin
      n_bad++; $display("FAIL recovery_stall: got %b want 0", bus.stall_o);
    end
    n_cmp++;
    if (bus.period_o !== PerTen) begin
      n_bad++; $display("FAIL recovery_period: got %0d want %0d", bus.period_o, PerTen);
    end
  endtask

  task automatic test_saturation();
    int n;
    for (int i = 0; i < 2; i++) begin
      wait_strobe(1'b1, 150, n);
      n_cmp++;
      if (sat_bus.pulse_count_o !== 3'd7) begin
        n_bad++; $display("FAIL sat_count[%0d]: got %0d want 7", i, sat_bus.pulse_count_o);
      end
    end
  endtask

  task automatic test_terminal_edge();
    int n;
    set_mode(3);
    wait_strobe(1'b0, 150, n);
    // Tach rises 94 cycles into the window; filtered rise lands on window cycle 99.
    repeat (94) tick();
    set_mode(0);
    wait_strobe(1'b0, 150, n);
    n_cmp++;
    if (n !== 6) begin
      n_bad++; $display("FAIL term_spacing: got %0d want 6", n);
    end
    n_cmp++;
    if (bus.pulse_count_o !== 8'd1) begin
      n_bad++; $display("FAIL term_closing: got %0d want 1", bus.pulse_count_o);
    end
    wait_strobe(1'b0, 150, n);
    n_cmp++;
    if (bus.pulse_count_o !== 8'd0) begin
      n_bad++; $display("FAIL term_next: got %0d want 0", bus.pulse_count_o);
    end
    n_cmp++;
    if (bus.stall_o !== 1'b0) begin
      n_bad++; $display("FAIL term_stall: got %b want 0", bus.stall_o);
    end
  endtask

  task automatic test_enable();
    int n;
    bit seen;
    set_mode(1);
    wait_strobe(1'b0, 150, n);
    wait_strobe(1'b0, 150, n);
    n_cmp++;
    if (bus.pulse_count_o !== 8'd10) begin
      n_bad++; $display("FAIL pre_disable_count: got %0d want 10", bus.pulse_count_o);
    end
    repeat (30) tick();
    bus.enable_i = 1'b0;
    seen = 1'b0;
    repeat (150) begin
      tick();
      if (bus.count_valid_o) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL disabled_strobe: got strobe want none");
    end
    n_cmp++;
    if (bus.pulse_count_o !== 8'd10) begin
      n_bad++; $display("FAIL disabled_hold: got %0d want 10", bus.pulse_count_o);
    end
    bus.enable_i = 1'b1;
    wait_strobe(1'b0, 150, n);
    n_cmp++;
    if (n !== 100) begin
      n_bad++; $display("FAIL reenable_spacing: got %0d want 100", n);
    end
    n_cmp++;
    if (bus.pulse_count_o !== 8'd10) begin
      n_bad++; $display("FAIL reenable_count: got %0d want 10", bus.pulse_count_o);
    end
    n_cmp++;
    if (bus.period_o !== PerTen) begin
      n_bad++; $display("FAIL reenable_period: got %0d want %0d", bus.period_o, PerTen);
    end
  endtask

  task automatic test_enable_clears_stall();
    int n;
    set_mode(0);
    repeat (3) wait_strobe(1'b0, 150, n);
    n_cmp++;
    if (bus.stall_o !== 1'b1) begin
      n_bad++; $display("FAIL idle_stall: got %b want 1", bus.stall_o);
    end
    repeat (20) tick();
    bus.enable_i = 1'b0;
    tick();
    n_cmp++;
    if (bus.stall_o !== 1'b0) begin
      n_bad++; $display("FAIL disable_stall_clear: got %b want 0", bus.stall_o);
    end
    n_cmp++;
    if (bus.period_o !== PerOnes) begin
      n_bad++; $display("FAIL disable_period_hold: got %0h want %0h", bus.period_o, PerOnes);
    end
  endtask

  initial begin
    bus.tach_i     = 1'b1;
    sat_bus.tach_i = 1'b1;
    test_reset();
    test_steady();
    test_glitch();
    test_recovery();
    test_saturation();
    test_terminal_edge();
    test_enable();
    test_enable_clears_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
